// File: rtl/isa_pkg.sv
// ISA constants and the instruction decoder shared by the decode/issue slice.
package isa_pkg;
  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_LUI   = 4'hF;

  localparam logic [3:0] EXT_AND   = 4'h1;
  localparam logic [3:0] EXT_OR    = 4'h2;
  localparam logic [3:0] EXT_XOR   = 4'h3;
  localparam logic [3:0] EXT_ADD   = 4'h5;
  localparam logic [3:0] EXT_ADDU  = 4'h6;
  localparam logic [3:0] EXT_SUB   = 4'h9;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_MOV   = 4'hD;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STORE = 4'h4;
  localparam logic [3:0] EXT_LSH   = 4'h4;

  localparam logic [7:0] OPC_NOP = 8'h00;

  // Source of the B operand: register port, constant zero, or imm8 extended.
  typedef enum logic [1:0] {B_REG, B_ZERO, B_ZEXT, B_SEXT} bsrc_e;

  typedef struct packed {
    logic       rd_a;     // A comes from the register file
    logic       a_rsrc;   // A port addresses Rsrc instead of Rdest
    logic       rd_b;     // B comes from the register file
    logic       b_rdest;  // B port addresses Rdest instead of Rsrc
    bsrc_e      imm;
    logic       wr;
    logic       illegal;
    logic [7:0] opc;
  } dec_t;

  function automatic logic ext_legal(input logic [3:0] e);
    case (e)
      EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_ADDU,
      EXT_SUB, EXT_CMP, EXT_MOV: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic dec_t decode(input logic [15:0] ins);
    dec_t       d;
    logic [3:0] op;
    logic [3:0] ext;
    op  = ins[15:12];
    ext = ins[7:4];
    d   = '0;
    d.imm     = B_ZERO;
    d.illegal = 1'b1;
    d.opc     = OPC_NOP;
    if (op == OP_REG) begin
      if (ext_legal(ext)) begin
        d = '{rd_a: 1'b1, a_rsrc: 1'b0, rd_b: 1'b1, b_rdest: 1'b0, imm: B_REG,
              wr: (ext != EXT_CMP), illegal: 1'b0, opc: {OP_REG, ext}};
      end
    end else if (ext_legal(op)) begin
      // Immediate form reuses the ALU ext encoding as its op field.
      d.rd_a    = 1'b1;
      d.imm     = (op == EXT_ADD || op == EXT_SUB || op == EXT_CMP || op == EXT_MOV)
                  ? B_SEXT : B_ZEXT;
      d.wr      = (op != EXT_CMP);
      d.illegal = 1'b0;
      d.opc     = {4'h0, op};
    end else if (op == OP_MEM) begin
      if (ext == EXT_LOAD || ext == EXT_STORE) begin
        d.rd_a    = 1'b1;
        d.a_rsrc  = 1'b1;
        d.rd_b    = (ext == EXT_STORE);
        d.b_rdest = 1'b1;
        d.imm     = (ext == EXT_STORE) ? B_REG : B_ZERO;
        d.wr      = (ext == EXT_LOAD);
        d.illegal = 1'b0;
        d.opc     = {OP_MEM, ext};
      end
    end else if (op == OP_SHIFT) begin
      d.rd_a    = 1'b1;
      d.rd_b    = (ext == EXT_LSH);
      d.imm     = (ext == EXT_LSH) ? B_REG : B_ZERO;
      d.wr      = 1'b1;
      d.illegal = 1'b0;
      d.opc     = {OP_SHIFT, ext};
    end else if (op == OP_LUI) begin
      d.imm     = B_ZEXT;
      d.wr      = 1'b1;
      d.illegal = 1'b0;
      d.opc     = 8'hF0;
    end
    return d;
  endfunction
endpackage

// File: rtl/regfile16.sv
// 16x16 register file, one write port, two combinational read ports.
// DECODE_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile16
  import isa_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b
);
  logic [NREGS-1:0][15:0] mem;

  always_ff @(posedge clock) begin
    if (!reset)  mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

`ifdef DECODE_BYPASS_EN
  assign rdata_a = (we && waddr == raddr_a) ? wdata : mem[raddr_a];
  assign rdata_b = (we && waddr == raddr_b) ? wdata : mem[raddr_b];
`else
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
`endif
endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage feeding the 16-bit ALU, with per-register pending scoreboard.
// DECODE_BYPASS_EN lets a pending source issue in the cycle its writeback lands.
module decode_issue
  import isa_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic [7:0]  opcode,
  output logic [15:0] rdataA,
  output logic [15:0] rdataB,
  output logic        issue_valid,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic        illegal
);
  dec_t             d;
  logic [3:0]       rdest, rsrc, a_addr, b_addr;
  logic [15:0]      rda, rdb, a_val, b_val;
  logic [NREGS-1:0] pend, pend_nxt;
  logic             hit_a, hit_b, stall, accept;

  assign d      = decode(instr);
  assign rdest  = instr[11:8];
  assign rsrc   = instr[3:0];
  assign a_addr = d.a_rsrc  ? rsrc  : rdest;
  assign b_addr = d.b_rdest ? rdest : rsrc;

  regfile16 #(.NREGS(NREGS)) u_rf (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (a_addr),
    .raddr_b (b_addr),
    .rdata_a (rda),
    .rdata_b (rdb)
  );

`ifdef DECODE_BYPASS_EN
  assign hit_a = wb_en && (wb_addr == a_addr);
  assign hit_b = wb_en && (wb_addr == b_addr);
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  assign stall       = (d.rd_a && pend[a_addr] && !hit_a) ||
                       (d.rd_b && pend[b_addr] && !hit_b);
  assign instr_ready = reset && !stall;
  assign accept      = instr_valid && instr_ready;

  assign a_val = d.rd_a ? rda : 16'h0000;
  always_comb begin
    b_val = 16'h0000;
    case (d.imm)
      B_REG:   b_val = rdb;
      B_ZEXT:  b_val = {8'h00, instr[7:0]};
      B_SEXT:  b_val = {{8{instr[7]}}, instr[7:0]};
      default: b_val = 16'h0000;
    endcase
  end

  // Issue after writeback so a same-register set in one cycle wins.
  always_comb begin
    pend_nxt = pend;
    if (wb_en)          pend_nxt[wb_addr] = 1'b0;
    if (accept && d.wr) pend_nxt[rdest]   = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) pend <= '0;
    else        pend <= pend_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset || !accept) begin
      opcode      <= OPC_NOP;
      rdataA      <= '0;
      rdataB      <= '0;
      issue_valid <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      illegal     <= 1'b0;
    end else begin
      opcode      <= d.opc;
      rdataA      <= a_val;
      rdataB      <= b_val;
      issue_valid <= 1'b1;
      wr_en       <= d.wr;
      wr_addr     <= d.wr ? rdest : 4'h0;
      illegal     <= d.illegal;
    end
  end
endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue; expectations are queued at drive time.
module tb_decode_issue;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = 16'h0251;
  logic        instr_valid = 1'b1;
  logic        instr_ready;
  logic        wb_en = 1'b1;
  logic [3:0]  wb_addr = 4'h5;
  logic [15:0] wb_data = 16'h1234;
  logic [7:0]  opcode;
  logic [15:0] rdataA, rdataB;
  logic        issue_valid, wr_en, illegal;
  logic [3:0]  wr_addr;

  typedef struct {
    logic [7:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic        wr;
    logic [3:0]  wa;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 0;

  always #5 clock = ~clock;

  decode_issue dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .opcode      (opcode),
    .rdataA      (rdataA),
    .rdataB      (rdataB),
    .issue_valid (issue_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .illegal     (illegal)
  );

  function automatic exp_t mk(input logic [7:0] opc, input logic [15:0] a, input logic [15:0] b,
                              input logic wr, input logic [3:0] wa, input logic ill);
    exp_t x;
    x.opc = opc; x.a = a; x.b = b; x.wr = wr; x.wa = wa; x.ill = ill;
    return x;
  endfunction

  // Scoreboard: every issue pops one expectation; idle cycles must show zeros.
  always @(negedge clock) begin
    if (mon_on) begin
      n_cmp++;
      if (issue_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_issue got opcode=%h A=%h B=%h, none expected", opcode, rdataA, rdataB);
        end else begin
          e = q.pop_front();
          if (opcode !== e.opc || rdataA !== e.a || rdataB !== e.b || wr_en !== e.wr ||
              (e.wr && wr_addr !== e.wa) || illegal !== e.ill) begin
            n_bad++;
            $display("FAIL issue got op=%h A=%h B=%h wr=%b wa=%h ill=%b want op=%h A=%h B=%h wr=%b wa=%h ill=%b",
                     opcode, rdataA, rdataB, wr_en, wr_addr, illegal, e.opc, e.a, e.b, e.wr, e.wa, e.ill);
          end
        end
      end else if ({opcode, rdataA, rdataB, wr_en, illegal} !== 42'h0) begin
        n_bad++;
        $display("FAIL idle_outputs got op=%h A=%h B=%h wr=%b ill=%b want all 0",
                 opcode, rdataA, rdataB, wr_en, illegal);
      end
    end
  end

  // Drive one instruction that must be accepted in its first cycle.
  task automatic send(input logic [15:0] ins, input exp_t x, input string nm);
    instr = ins; instr_valid = 1'b1;
    q.push_back(x);
    @(negedge clock);
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready got %b want 1", nm, instr_ready);
    end
    @(posedge clock); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] a, input logic [15:0] dat);
    wb_en = 1'b1; wb_addr = a; wb_data = dat;
    @(posedge clock); #1;
    wb_en = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clock); #1;
    mon_on = 1;
    @(negedge clock);
    n_cmp++;
    if (instr_ready !== 1'b0) begin
      n_bad++; $display("FAIL ready_in_reset got %b want 0", instr_ready);
    end
    n_cmp++;
    if ({opcode, rdataA, rdataB, issue_valid, wr_en, wr_addr, illegal} !== 47'h0) begin
      n_bad++; $display("FAIL reset_outputs got op=%h A=%h B=%h iv=%b want all 0", opcode, rdataA, rdataB, issue_valid);
    end
    @(posedge clock); #1;
    instr_valid = 1'b0; wb_en = 1'b0; reset = 1'b1;
    // R5 must still be 0: the writeback during reset was ignored.
    send(16'h4545, mk(8'h44, 16'h0, 16'h0, 1'b0, 4'h0, 1'b0), "store_r5");
  endtask

  task automatic test_movi;
    send(16'hD1FD, mk(8'h0D, 16'h0, 16'hFFFD, 1'b1, 4'h1, 1'b0), "movi");
  endtask

  task automatic test_hazard;
    instr = 16'h0251; instr_valid = 1'b1;
    q.push_back(mk(8'h05, 16'h0, 16'hFFFD, 1'b1, 4'h2, 1'b0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_cmp++;
      if (instr_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_pending_src got %b want 0", instr_ready);
      end
      if (i == 0) begin
        @(posedge clock); #1;
      end
    end
    @(posedge clock); #1;
    wb_en = 1'b1; wb_addr = 4'h1; wb_data = 16'hFFFD;
    @(negedge clock);
    n_cmp++;
`ifdef DECODE_BYPASS_EN
    if (instr_ready !== 1'b1) begin
      n_bad++; $display("FAIL wb_cycle_ready got %b want 1", instr_ready);
    end
    @(posedge clock); #1;
    wb_en = 1'b0; instr_valid = 1'b0;
`else
    if (instr_ready !== 1'b0) begin
      n_bad++; $display("FAIL wb_cycle_ready got %b want 0", instr_ready);
    end
    @(posedge clock); #1;
    wb_en = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_bad++; $display("FAIL after_wb_ready got %b want 1", instr_ready);
    end
    @(posedge clock); #1;
    instr_valid = 1'b0;
`endif
    wb(4'h2, 16'h0007);
  endtask

  task automatic test_cmp;
    wb(4'h3, 16'h0005);
    wb(4'h4, 16'h0005);
    send(16'h03B4, mk(8'h0B, 16'h5, 16'h5, 1'b0, 4'h0, 1'b0), "cmp");
    // A stall here would mean CMP wrongly marked R3 pending.
    send(16'h4343, mk(8'h44, 16'h5, 16'h5, 1'b0, 4'h0, 1'b0), "store_r3");
  endtask

  task automatic test_lui;
    send(16'hF7AB, mk(8'hF0, 16'h0, 16'h00AB, 1'b1, 4'h7, 1'b0), "lui");
    send(16'hF7AB, mk(8'hF0, 16'h0, 16'h00AB, 1'b1, 4'h7, 1'b0), "lui_dest_pending");
    wb(4'h7, 16'h0000);
  endtask

  task automatic test_illegal;
    send(16'h7000, mk(8'h00, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1), "illegal_op");
    send(16'h1612, mk(8'h01, 16'h0, 16'h0012, 1'b1, 4'h6, 1'b0), "andi_after_illegal");
  endtask

  task automatic test_back_to_back;
    send(16'h9880, mk(8'h09, 16'h0, 16'hFF80, 1'b1, 4'h8, 1'b0), "subi_sext");
    send(16'h4A03, mk(8'h40, 16'h5, 16'h0, 1'b1, 4'hA, 1'b0), "load");
    send(16'h8B24, mk(8'h82, 16'h0, 16'h0, 1'b1, 4'hB, 1'b0), "shift");
    send(16'h0000, mk(8'h00, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1), "illegal_ext");
  endtask

  task automatic test_reset_stall;
    send(16'hD1FD, mk(8'h0D, 16'hFFFD, 16'hFFFD, 1'b1, 4'h1, 1'b0), "movi_again");
    instr = 16'h0251; instr_valid = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (instr_ready !== 1'b0) begin
      n_bad++; $display("FAIL stall_before_reset got %b want 0", instr_ready);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; instr_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({opcode, rdataA, rdataB, issue_valid, wr_en, wr_addr, illegal} !== 47'h0) begin
      n_bad++; $display("FAIL outputs_after_reset got op=%h A=%h B=%h iv=%b want all 0", opcode, rdataA, rdataB, issue_valid);
    end
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_reset got %b want 1", instr_ready);
    end
    @(posedge clock); #1;
    send(16'h0251, mk(8'h05, 16'h0, 16'h0, 1'b1, 4'h2, 1'b0), "add_after_reset");
  endtask

  initial begin
    test_reset();
    test_movi();
    test_hazard();
    test_cmp();
    test_lui();
    test_illegal();
    test_back_to_back();
    test_reset_stall();
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drained got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_issue.md
# decode_issue

Decode/issue stage sitting directly upstream of the 16-bit ALU. Accepts 16-bit instructions over a valid/ready handshake, reads a 16×16 register file, and presents a registered `opcode`/`rdataA`/`rdataB` triple to the ALU. It also provides the destination tag for writeback and holds the writeback write port. A per-register scoreboard stalls issue while a source operand's result is still in flight.

## Interface
- `NREGS`, 16: register count; address width is 4.
- `clock  in  1`: rising-edge clock.
- `reset  in  1`: synchronous, active-low.
- `instr  in  16`: instruction; [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc; imm8 = [7:0].
- `instr_valid  in  1`: `instr` is presented.
- `instr_ready  out  1`: combinational; instruction accepted on a clock edge when valid & ready.
- `wb_en  in  1`: writeback strobe from the downstream stage.
- `wb_addr  in  4`: writeback register.
- `wb_data  in  16`: writeback value.
- `opcode  out  8`: to the ALU `opcode`.
- `rdataA  out  16`: to the ALU `rdataA`.
- `rdataB  out  16`: to the ALU `rdataB`.
- `issue_valid  out  1`: one-cycle pulse per issued instruction.
- `wr_en  out  1`: issued instruction writes Rdest.
- `wr_addr  out  4`: destination register of the issued instruction.
- `illegal  out  1`: one-cycle pulse when an undefined instruction is consumed.

## Operation
Decode by op:
- 0000 (register ALU op):
  - opcode={0000,ext}; A=R[Rdest], B=R[Rsrc].
  - Writes Rdest unless ext=1011 (CMP).
  - Legal ext values: 0001, 0010, 0011, 0101, 0110, 1001, 1011, 1101.
- op ∈ {0001, 0010, 0011, 0101, 0110, 1001, 1011, 1101} (immediate form):
  - opcode={0000,op}; A=R[Rdest]; no B register read.
  - B = sign-extended imm8 for op 0101, 1001, 1011, 1101; zero-extended otherwise.
  - Write rule same as the register form.
- 0100 (memory):
  - ext=0000 LOAD: A=R[Rsrc], B=0; writes Rdest.
  - ext=0100 STORE: A=R[Rsrc], B=R[Rdest]; no write.
  - opcode={0100,ext}.
- 1000 (shift):
  - opcode={1000,ext}; A=R[Rdest]; writes Rdest.
  - B=R[Rsrc] if ext=0100, else B=0.
- 1111 (LUI): opcode=8'hF0; A=0; B={8'h00,imm8}; writes Rdest.
- Any other op/ext: consumed, `illegal`=1, opcode=8'h00, no write, no scoreboard change.

Scoreboard:
- One `pend` bit per register.
- Issue of a writing instruction sets `pend[Rdest]`.
- `wb_en` clears `pend[wb_addr]`.
- If both happen to the same register in one cycle, set wins.

Hazard:
- `instr_ready` = 0 while any register read by the current instruction has `pend`=1.
- Exception: with bypass enabled, a pending source that equals `wb_addr` while `wb_en`=1 does not stall.
- Rdest pending alone does not stall unless Rdest is also read.

Register file:
- Written on `wb_en` at the clock edge.
- Read is combinational at the accept cycle.

## Timing
- Accept at edge N; `opcode`/`rdataA`/`rdataB`/`wr_*`/`issue_valid` are registered at edge N, so the ALU captures them at edge N+1.
- Outputs hold the last issued value for exactly one cycle. In cycles with no issue: opcode=8'h00, rdataA=rdataB=0, issue_valid=wr_en=0.
- Issue throughput: one instruction per cycle with no hazard.
- Same-cycle writeback and read of the same register: behaviour set by the config macro.
- Reset (synchronous, reset=0):
  - All R[i]=0; all `pend`=0.
  - All outputs 0; `instr_ready` is 0 during reset.
  - An instruction presented in the reset cycle is dropped.
  - A writeback in the reset cycle is ignored.
- Reset asserted mid-stall: clears the scoreboard; the stalled instruction is dropped unless re-presented.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - A read of R[x] in a cycle with `wb_en` and `wb_addr`=x returns `wb_data`.
  - A pending source matching that writeback issues in that same cycle.
- Undefined:
  - The read returns the old value.
  - Issue waits until the cycle after the writeback, i.e. one extra stall cycle.

## Structure
- Shared package `isa_pkg`:
  - op and ext constants: OP_REG, OP_MEM, OP_SHIFT, OP_LUI, EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_ADDU, EXT_SUB, EXT_CMP, EXT_MOV, EXT_LOAD, EXT_STORE, EXT_LSH.
  - NOP opcode 8'h00.
  - Decoded-control struct typedef: reads A, reads B, writes, immediate kind, illegal.
- Sub-module `regfile16`:
  - 16×16 storage, one write port, two combinational read ports.
  - Optional bypass under `DECODE_BYPASS_EN`.
  - Synchronous active-low clear.

## Test plan
- Reset then MOVI R1,#-3 (instr=16'hD1FD): next cycle opcode=8'h0D, rdataB=16'hFFFD, wr_en=1, wr_addr=1; `pend[1]` set.
- ADD R2,R1 immediately after the above with no writeback: `instr_ready`=0. When wb_en=1, wb_addr=1, wb_data=16'hFFFD:
  - With the macro: issues that cycle with rdataB=16'hFFFD.
  - Without the macro: issues the following cycle.
- CMP R3,R4 (16'h03B4) with R3=5, R4=5: opcode=8'h0B, rdataA=rdataB=5, wr_en=0, scoreboard unchanged.
- LUI R7,#8'hAB (16'hF7AB): opcode=8'hF0, rdataA=0, rdataB=16'h00AB, wr_addr=7.
- Undefined op 16'h7000: `illegal` pulses, opcode=8'h00, issue_valid=1, wr_en=0; the next instruction issues on the following cycle.
- Reset=0 while stalled on a pending R1: the next cycle after reset release, all `pend`=0, all outputs 0, and a re-presented ADD R2,R1 issues with rdataA=rdataB=0.
